// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: source count, mcause encoding
// and the service FSM state type.
package irq_controller_pkg;

  localparam int          IRQ_NUM         = 16;
  localparam int          IRQ_IDX_W       = 4;
  localparam logic [31:0] MCAUSE_IRQ_BASE = 32'h8000_0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2,
    FIN  = 2'd3
  } irq_state_e;

  function automatic logic [31:0] mcause_of(input logic [IRQ_IDX_W-1:0] idx);
    return MCAUSE_IRQ_BASE + {{(32-IRQ_IDX_W){1'b0}}, idx};
  endfunction

  function automatic logic [IRQ_NUM-1:0] onehot_of(input logic [IRQ_IDX_W-1:0] idx);
    return IRQ_NUM'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Request/ack/completion bundle between interrupt sources, the CSR file and the
// decoder on one side (master) and the interrupt controller (slave).
interface irq_controller_if;
  import irq_controller_pkg::*;

  logic [IRQ_NUM-1:0] int_req_i;
  logic [IRQ_NUM-1:0] mie_i;
  logic               int_ack_i;
  logic               int_rst_i;
  logic               int_o;
  logic [31:0]        mcause_o;
  logic [IRQ_NUM-1:0] int_fin_o;

  modport slave (
    input  int_req_i, mie_i, int_ack_i, int_rst_i,
    output int_o, mcause_o, int_fin_o
  );

  modport master (
    output int_req_i, mie_i, int_ack_i, int_rst_i,
    input  int_o, mcause_o, int_fin_o
  );

endinterface

// File: rtl/irq_arbiter.sv
// Combinational interrupt arbiter. Fixed lowest-index priority by default;
// round-robin starting at ptr_i when IRQ_ROUND_ROBIN_EN is defined.
module irq_arbiter
  import irq_controller_pkg::*;
(
  input  logic [IRQ_NUM-1:0]   elig_i,
  input  logic [IRQ_IDX_W-1:0] ptr_i,
  output logic [IRQ_NUM-1:0]   grant_o,
  output logic [IRQ_IDX_W-1:0] idx_o,
  output logic                 valid_o
);

  // Scan from the far end toward the preferred start so the last hit wins.
  always_comb begin
    idx_o = '0;
`ifdef IRQ_ROUND_ROBIN_EN
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (elig_i[ptr_i + IRQ_IDX_W'(k)]) begin
        idx_o = ptr_i + IRQ_IDX_W'(k);
      end
    end
`else
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (elig_i[k]) begin
        idx_o = IRQ_IDX_W'(k);
      end
    end
`endif
  end

`ifndef IRQ_ROUND_ROBIN_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  assign valid_o = |elig_i;
  assign grant_o = valid_o ? onehot_of(idx_o) : '0;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: arbitrates enabled level requests, presents one to the core
// and tracks it through ack/mret to a completion pulse. IRQ_ROUND_ROBIN_EN selects round-robin.
module irq_controller
  import irq_controller_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  irq_controller_if.slave   bus
);

  irq_state_e           state_q, state_d;
  logic [IRQ_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]          mcause_q, mcause_d;
  logic [IRQ_IDX_W-1:0] ptr;

  logic [IRQ_NUM-1:0]   elig;
  logic [IRQ_NUM-1:0]   arb_grant_unused;
  logic [IRQ_IDX_W-1:0] arb_idx;
  logic                 arb_valid;

  assign elig = bus.int_req_i & bus.mie_i;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IRQ_IDX_W-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  irq_arbiter u_arb (
    .elig_i  (elig),
    .ptr_i   (ptr),
    .grant_o (arb_grant_unused),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mcause_q <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mcause_q <= mcause_d;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Winner index and cause are captured only on IDLE->PEND and held until FIN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mcause_d = mcause_q;
`ifdef IRQ_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d  = PEND;
          idx_d    = arb_idx;
          mcause_d = mcause_of(arb_idx);
`ifdef IRQ_ROUND_ROBIN_EN
          ptr_d    = arb_idx + IRQ_IDX_W'(1);
`endif
        end
      end
      PEND: begin
        if (bus.int_ack_i) state_d = SERV;
      end
      SERV: begin
        if (bus.int_rst_i) state_d = FIN;
      end
      FIN: begin
        state_d  = IDLE;
        mcause_d = '0;
      end
      default: begin
        state_d  = IDLE;
        mcause_d = '0;
      end
    endcase
  end

  assign bus.int_o     = (state_q == PEND);
  assign bus.mcause_o  = mcause_q;
  assign bus.int_fin_o = (state_q == FIN) ? onehot_of(idx_q) : '0;

endmodule
